median_unit_arbiter: RTL and testbench
======================================

// Module: median_unit_arbiter
// PURPOSE
//   Shares one 3-input median functional unit (ports rst_n, word0..2, median_word)
//   among NREQ requesters. Runs the unit's rst_n bring-up sequence, then grants
//   one request per cycle using a round-robin policy. It drives the unit's word
//   inputs and returns each result to the requester that issued it.
//   Sits between HLS-generated channel readers and the shared median instance.
// PARAMETERS
//   NREQ          3   number of requesters (>=2)
//   WIDTH         32  data word width
//   MED_LAT       1   median unit latency, word inputs registered -> median_word valid (cycles, >=1)
//   RST_LO_CYCLES 1   cycles m_rst_n is held low during bring-up (>=1)
// PORTS
//   clk           in   1            clock
//   rst           in   1            synchronous reset, active-high
//   req_valid     in   NREQ         request i presents a sample
//   req_ready     out  NREQ         one-hot grant; accept = valid&ready at posedge
//   req_word0     in   NREQ*WIDTH   word0 of request i at bits [i*WIDTH +: WIDTH]
//   req_word1     in   NREQ*WIDTH   word1, same packing
//   req_word2     in   NREQ*WIDTH   word2, same packing
//   resp_valid    out  NREQ         one-hot 1-cycle pulse: result for requester i
//   resp_data     out  WIDTH        median result; valid only while resp_valid!=0
//   m_rst_n       out  1            to median unit rst_n
//   m_word0       out  WIDTH        to median unit word0 (registered)
//   m_word1       out  WIDTH        to median unit word1 (registered)
//   m_word2       out  WIDTH        to median unit word2 (registered)
//   m_median_word in   WIDTH        from median unit
//   valid         out  1            high in RUN state (unit initialised, accepting)
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=INIT_HI, m_rst_n=1, m_word*=0, req_ready=0,
//     resp_valid=0, resp_data=0, valid=0, rr pointer=NREQ-1, tag pipeline cleared.
//   FSM: INIT_HI (1 cyc, m_rst_n=1) -> INIT_LO (RST_LO_CYCLES cyc, m_rst_n=0)
//     -> INIT_REL (1 cyc, m_rst_n=1) -> RUN (m_rst_n=1, valid=1). RUN exits only on rst.
//   req_ready=0 in all states except RUN. In RUN, req_ready is combinational: the
//     one-hot grant is the first asserted req_valid scanning from ptr+1 mod NREQ.
//   The rr pointer updates to the granted index on accept and holds when idle.
//   Worst-case wait for a continuously-valid requester: NREQ-1 cycles.
//   Accept at edge t: m_word* <= selected words; tag (one-hot index) enters a
//     MED_LAT+1 deep shift register. At edge t+1+MED_LAT: resp_data <= m_median_word,
//     resp_valid <= tag. Total latency accept->resp_valid = MED_LAT+2 cycles.
//   Throughput: 1 accept/cycle. Responses are in issue order. No response
//     backpressure; requesters must always take resp pulses.
//   m_word* hold their last value on idle cycles. A bubble tag (0) produces
//     resp_valid=0.
//   Requests with req_valid high during INIT_* are not accepted (held by the
//     requester). The first grant occurs in the first RUN cycle.
//   rst asserted mid-operation: in-flight tags are dropped (no resp_valid after
//     the reset edge) and the FSM restarts at INIT_HI.
//   NREQ=1 is out of scope (parameter check fails elaboration).
// TESTING (NREQ=3, MED_LAT=1, RST_LO_CYCLES=1, bench median reference model)
//   Bring-up: rst for 2 cyc, then release -> m_rst_n=1,0,1 on cycles 0,1,2;
//     valid=1 and req_ready usable from cycle 3.
//   Single: req1 words (5,9,7) accepted at t -> resp_valid=3'b010 and
//     resp_data=7 at t+3; all other cycles resp_valid=0.
//   Contention: all req_valid=1 continuously -> grants 0,1,2,0,1,2...;
//     responses tagged 001,010,100 repeating, each 3 cycles after its grant.
//   Streaming: only req2 valid, 8 samples back-to-back -> 8 accepts in 8 cycles;
//     8 in-order results with correct medians incl. ties (4,4,1)->4.
//   Reset mid-flight: 2 samples accepted, rst at next edge -> no resp_valid;
//     m_rst_n sequence repeats, valid drops to 0 until RUN.
//   Init gating: req0 valid from reset release -> req_ready=0 through INIT_REL;
//     req0 accepted in the first RUN cycle.

Source files
------------

// File: rtl/median_unit_arbiter.sv
// Purpose: round-robin share of one 3-input median unit among NREQ requesters, incl. unit rst_n bring-up.
// Latency: accept -> resp_valid pulse is MED_LAT+2 cycles; one accept per cycle, responses in issue order.
// Backpressure: req_ready is a combinational one-hot grant in RUN only; responses cannot be stalled.
module median_unit_arbiter #(
    parameter int NREQ          = 3,
    parameter int WIDTH         = 32,
    parameter int MED_LAT       = 1,
    parameter int RST_LO_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_word0,
    input  logic [NREQ*WIDTH-1:0] req_word1,
    input  logic [NREQ*WIDTH-1:0] req_word2,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  m_rst_n,
    output logic [WIDTH-1:0]      m_word0,
    output logic [WIDTH-1:0]      m_word1,
    output logic [WIDTH-1:0]      m_word2,
    input  logic [WIDTH-1:0]      m_median_word,
    output logic                  valid
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(RST_LO_CYCLES + 1);

    if (NREQ < 2) begin : g_bad_nreq
        $error("median_unit_arbiter: NREQ must be at least 2");
    end
    if (MED_LAT < 1) begin : g_bad_lat
        $error("median_unit_arbiter: MED_LAT must be at least 1");
    end
    if (RST_LO_CYCLES < 1) begin : g_bad_lo
        $error("median_unit_arbiter: RST_LO_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        INIT_HI  = 2'd0,
        INIT_LO  = 2'd1,
        INIT_REL = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   lo_cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic [NREQ-1:0] grant;
    logic            accept;
    // Index of the request being issued travels alongside the unit's pipeline
    logic [NREQ-1:0] tag_pipe [MED_LAT+1];

    // State register and low-phase counter for the unit's rst_n pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT_HI;
            lo_cnt <= '0;
        end else begin
            state  <= state_nxt;
            lo_cnt <= (state == INIT_LO) ? lo_cnt + 1'b1 : '0;
        end
    end

    // Bring-up sequencing: high, low for RST_LO_CYCLES, high, then run forever
    always_comb begin
        state_nxt = state;
        case (state)
            INIT_HI:  state_nxt = INIT_LO;
            INIT_LO:  if (lo_cnt == CW'(RST_LO_CYCLES - 1)) state_nxt = INIT_REL;
            INIT_REL: state_nxt = RUN;
            RUN:      state_nxt = RUN;
            default:  state_nxt = INIT_HI;
        endcase
    end

    assign m_rst_n = (state != INIT_LO);
    assign valid   = (state == RUN);

    // Round-robin grant: first valid requester scanning upward from ptr+1
    always_comb begin
        grant     = '0;
        grant_idx = ptr;
        accept    = 1'b0;
        cand      = '0;
        if (state == RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = PW'((int'(ptr) + k) % NREQ);
                if (!accept && req_valid[cand]) begin
                    accept      = 1'b1;
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    assign req_ready = grant;

    // Launch the granted words into the unit; idle cycles keep the last operands
    always_ff @(posedge clk) begin
        if (rst) begin
            m_word0 <= '0;
            m_word1 <= '0;
            m_word2 <= '0;
            ptr     <= PW'(NREQ - 1);
        end else if (accept) begin
            m_word0 <= req_word0[int'(grant_idx)*WIDTH +: WIDTH];
            m_word1 <= req_word1[int'(grant_idx)*WIDTH +: WIDTH];
            m_word2 <= req_word2[int'(grant_idx)*WIDTH +: WIDTH];
            ptr     <= grant_idx;
        end
    end

    // Tag shift register aligned to the unit latency, then the response register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MED_LAT; i++) tag_pipe[i] <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            tag_pipe[0] <= accept ? grant : '0;
            for (int i = 1; i <= MED_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            resp_valid <= tag_pipe[MED_LAT];
            if (tag_pipe[MED_LAT] != '0) resp_data <= m_median_word;
        end
    end

endmodule

// File: tb/tb_median_unit_arbiter.sv
module tb_median_unit_arbiter;
    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_word0, req_word1, req_word2;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic           m_rst_n;
    logic [W-1:0]   m_word0, m_word1, m_word2;
    logic [W-1:0]   m_median_word;
    logic           valid;

    always #5 clk = ~clk;

    median_unit_arbiter #(.NREQ(N), .WIDTH(W), .MED_LAT(1), .RST_LO_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_word0(req_word0), .req_word1(req_word1), .req_word2(req_word2),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .m_rst_n(m_rst_n), .m_word0(m_word0), .m_word1(m_word1), .m_word2(m_word2),
        .m_median_word(m_median_word), .valid(valid)
    );

    // Reference median unit, one cycle from registered words to result
    function automatic logic [W-1:0] med3(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        logic [W-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction

    always @(posedge clk) m_median_word <= med3(m_word0, m_word1, m_word2);

    typedef struct {
        logic [N-1:0] tag;
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           grant_log[$];
    logic [W-1:0] exp_med [N];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops on every response, pushes expectations on every accept
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid !== '0) begin
            if (sbq.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("resp_tag", 64'(resp_valid), 64'(e.tag));
                chk("resp_data", 64'(resp_data), 64'(e.data));
                chk("resp_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (rst) begin
            sbq.delete();
        end else if (req_ready !== '0) begin
            chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    sbq.push_back('{tag: N'(1 << i), data: exp_med[i], cyc: cyc + 3});
                    grant_log.push_back(i);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] m);
        req_word0[i*W +: W] = a;
        req_word1[i*W +: W] = b;
        req_word2[i*W +: W] = c;
        exp_med[i] = m;
    endtask

    // Called just after the reset-releasing edge: checks cycles 0..3
    task automatic check_bringup();
        @(negedge clk);
        chk("bu_rst_n_c0", 64'(m_rst_n), 64'd1);
        chk("bu_valid_c0", 64'(valid), 64'd0);
        chk("bu_ready_c0", 64'(req_ready), 64'd0);
        chk("bu_resp_c0", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("bu_rst_n_c1", 64'(m_rst_n), 64'd0);
        chk("bu_valid_c1", 64'(valid), 64'd0);
        chk("bu_ready_c1", 64'(req_ready), 64'd0);
        chk("bu_resp_c1", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("bu_rst_n_c2", 64'(m_rst_n), 64'd1);
        chk("bu_valid_c2", 64'(valid), 64'd0);
        chk("bu_ready_c2", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("bu_rst_n_c3", 64'(m_rst_n), 64'd1);
        chk("bu_valid_c3", 64'(valid), 64'd1);
    endtask

    // Streaming vectors for requester 2 with hand-computed medians
    logic [W-1:0] sw0 [8] = '{32'd4, 32'd1, 32'd9, 32'd7, 32'd0,   32'd20, 32'hFFFF_FFFF, 32'd6};
    logic [W-1:0] sw1 [8] = '{32'd4, 32'd2, 32'd3, 32'd7, 32'd100, 32'd10, 32'd0,         32'd2};
    logic [W-1:0] sw2 [8] = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd50,  32'd20, 32'd8,         32'd6};
    logic [W-1:0] smd [8] = '{32'd4, 32'd2, 32'd5, 32'd7, 32'd50,  32'd20, 32'd8,         32'd6};
    int           exp_g [9] = '{2, 0, 1, 2, 0, 1, 2, 0, 1};

    initial begin
        int base;
        rst       = 1'b1;
        req_valid = '0;
        req_word0 = '0;
        req_word1 = '0;
        req_word2 = '0;
        for (int i = 0; i < N; i++) exp_med[i] = '0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_m_rst_n", 64'(m_rst_n), 64'd1);
        chk("rst_m_word0", 64'(m_word0), 64'd0);
        chk("rst_m_word2", 64'(m_word2), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);

        // Release with req0 already valid: gated until the first RUN cycle
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 32'd3, 32'd1, 32'd2, 32'd2);
        req_valid = 3'b001;
        check_bringup();
        chk("gate_first_run_grant", 64'(req_ready), 64'b001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Single request from requester 1
        set_req(1, 32'd5, 32'd9, 32'd7, 32'd7);
        req_valid = 3'b010;
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'b010);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;

        // Contention: pointer sits at 1, so rotation starts at 2
        set_req(0, 32'd1, 32'd2, 32'd3, 32'd2);
        set_req(1, 32'd10, 32'd30, 32'd20, 32'd20);
        set_req(2, 32'd100, 32'd100, 32'd50, 32'd100);
        grant_log.delete();
        req_valid = 3'b111;
        repeat (9) @(posedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("cont_grant_count", 64'(grant_log.size()), 64'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < grant_log.size()) chk("cont_grant_order", 64'(grant_log[k]), 64'(exp_g[k]));
        end

        // Streaming: requester 2 back-to-back
        base = grant_log.size();
        for (int k = 0; k < 8; k++) begin
            set_req(2, sw0[k], sw1[k], sw2[k], smd[k]);
            req_valid = 3'b100;
            @(negedge clk);
            chk("stream_ready", 64'(req_ready), 64'b100);
            @(posedge clk); #1;
        end
        req_valid = '0;
        chk("stream_accepts", 64'(grant_log.size() - base), 64'd8);
        repeat (5) @(posedge clk);
        #1;
        chk("stream_drained", 64'(sbq.size()), 64'd0);

        // Reset mid-flight: two accepts, then reset drops them
        set_req(0, 32'd11, 32'd12, 32'd13, 32'd12);
        req_valid = 3'b001;
        @(posedge clk); #1;
        set_req(0, 32'd30, 32'd20, 32'd10, 32'd20);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bringup();
        repeat (6) @(posedge clk);
        #1;
        chk("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
